// File: rtl/ysyx_23060072_id2ex.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_id2ex
//
// Pipeline register between the decode (ID) and execute (EX) stages, with
// load-use hazard detection.
//
// When the instruction sitting in id2ex is a load whose destination matches
// a source register of the instruction now in decode, the stage inserts a
// one-cycle bubble. Decode is held during that cycle, then accepted on the
// following cycle once the load has moved on. A saturating counter records
// how many bubble cycles were actually inserted.
//
// Parameters
//   CTRL_W             width of the opaque EX control bundle
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   id_valid/id_ready  handshake with decode; payload is captured on
//                      id_valid & id_ready
//   id_*               decoded payload: pc, operands, register numbers,
//                      qualifiers and the EX control bundle
//   ex_ready           EX consumes the current id2ex contents this cycle
//   flush              redirect from EX; kills the id2ex contents and blocks
//                      capture for that cycle
//   id2ex_*            registered stage contents
//   load_use_stall     combinational: a load-use bubble is inserted now
//   load_use_cnt       saturating count of inserted bubble cycles
//
// Configuration macro
//   YSYX_23060072_LOAD_STORE_FWD_EN
//     When defined, a store does not stall on its rs2 (store data), because
//     that value is forwarded later at the LSU stage. The address source rs1
//     still stalls. When undefined, every instruction type stalls on either
//     source.
// ---------------------------------------------------------------------------
module ysyx_23060072_id2ex #(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_operand_a,
  input  logic [31:0]       id_operand_b,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_wb_addr,
  input  logic              id_has_rs1,
  input  logic              id_has_rs2,
  input  logic              id_wb_flag,
  input  logic              id_load_flag,
  input  logic              id_store_flag,
  input  logic [CTRL_W-1:0] id_ctrl,

  input  logic              ex_ready,
  input  logic              flush,

  output logic              id2ex_valid,
  output logic [31:0]       id2ex_pc,
  output logic [31:0]       id2ex_operand_a,
  output logic [31:0]       id2ex_operand_b,
  output logic [4:0]        id2ex_rs1_addr,
  output logic [4:0]        id2ex_rs2_addr,
  output logic [4:0]        id2ex_wb_addr,
  output logic              id2ex_has_rs1,
  output logic              id2ex_has_rs2,
  output logic              id2ex_wb_flag,
  output logic              id2ex_load_flag,
  output logic              id2ex_store_flag,
  output logic [CTRL_W-1:0] id2ex_ctrl,

  output logic              load_use_stall,
  output logic [15:0]       load_use_cnt
);

  logic        producer_is_load;
  logic        hazard_rs1;
  logic        hazard_rs2_raw;
  logic        hazard_rs2;
  logic        fire;
  logic [15:0] stall_cnt_q;

  // A hazard can only come from a valid load in id2ex that really writes a
  // register other than x0; x0 reads always return zero, so they never wait.
  assign producer_is_load = id2ex_valid & id2ex_load_flag & id2ex_wb_flag &
                            (id2ex_wb_addr != 5'd0);

  assign hazard_rs1     = id_valid & id_has_rs1 & producer_is_load &
                          (id_rs1_addr == id2ex_wb_addr);
  assign hazard_rs2_raw = id_valid & id_has_rs2 & producer_is_load &
                          (id_rs2_addr == id2ex_wb_addr);

`ifdef YSYX_23060072_LOAD_STORE_FWD_EN
  // Store data (rs2) is picked up later by LSU-stage forwarding, so a store
  // only needs to wait for its address operand.
  assign hazard_rs2 = hazard_rs2_raw & ~id_store_flag;
`else
  assign hazard_rs2 = hazard_rs2_raw;
`endif

  // A flush discards the decode instruction anyway, so a bubble on its
  // behalf is neither reported nor counted.
  assign load_use_stall = (hazard_rs1 | hazard_rs2) & ~flush;

  // Decode is accepted when there is no bubble, no redirect, and the stage
  // is either empty or being drained by EX this cycle.
  assign id_ready = ~load_use_stall & ~flush & (~id2ex_valid | ex_ready);
  assign fire     = id_valid & id_ready;

  assign load_use_cnt = stall_cnt_q;

  // Valid bit. Flush wins over everything. Otherwise a capture sets valid,
  // and a drain without a capture (including the load-use bubble) clears it.
  // With EX not ready and no flush the stage simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id2ex_valid <= 1'b0;
    end else if (flush) begin
      id2ex_valid <= 1'b0;
    end else if (fire) begin
      id2ex_valid <= 1'b1;
    end else if (ex_ready) begin
      id2ex_valid <= 1'b0;
    end
  end

  // Payload registers only change on a capture. Clearing valid leaves the
  // old payload in place, which keeps toggling down on the wide datapath.
  // Flush needs no term here because it already forces id_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id2ex_pc         <= '0;
      id2ex_operand_a  <= '0;
      id2ex_operand_b  <= '0;
      id2ex_rs1_addr   <= '0;
      id2ex_rs2_addr   <= '0;
      id2ex_wb_addr    <= '0;
      id2ex_has_rs1    <= 1'b0;
      id2ex_has_rs2    <= 1'b0;
      id2ex_wb_flag    <= 1'b0;
      id2ex_load_flag  <= 1'b0;
      id2ex_store_flag <= 1'b0;
      id2ex_ctrl       <= '0;
    end else if (fire) begin
      id2ex_pc         <= id_pc;
      id2ex_operand_a  <= id_operand_a;
      id2ex_operand_b  <= id_operand_b;
      id2ex_rs1_addr   <= id_rs1_addr;
      id2ex_rs2_addr   <= id_rs2_addr;
      id2ex_wb_addr    <= id_wb_addr;
      id2ex_has_rs1    <= id_has_rs1;
      id2ex_has_rs2    <= id_has_rs2;
      id2ex_wb_flag    <= id_wb_flag;
      id2ex_load_flag  <= id_load_flag;
      id2ex_store_flag <= id_store_flag;
      id2ex_ctrl       <= id_ctrl;
    end
  end

  // Bubble counter. A cycle counts only when the bubble actually enters the
  // pipe (EX draining the load); a stall while EX is itself blocked is just
  // a hold. The count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (load_use_stall && ex_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_id2ex.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060072_id2ex
//
// Self-checking bench for ysyx_23060072_id2ex. Rows of a vector table carry
// the decode-side inputs plus the expected handshake outputs for that cycle
// and the expected stage contents after the next rising edge. Each row is
// driven on the falling edge; its expectation is queued and popped after the
// rising edge. Payload values are derived from a per-instruction tag so the
// whole stage contents can be checked. Hand-written sequences cover reset in
// mid-operation and counter saturation.
// Works with or without YSYX_23060072_LOAD_STORE_FWD_EN defined.
// ---------------------------------------------------------------------------
module tb_ysyx_23060072_id2ex;

`ifdef YSYX_23060072_LOAD_STORE_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  localparam int NF = 1 - FWD;

  typedef struct packed {
    logic [15:0] id;
    logic        vld;
    logic [4:0]  rs1;
    logic        hr1;
    logic [4:0]  rs2;
    logic        hr2;
    logic [4:0]  wb;
    logic        wbf;
    logic        ld;
    logic        st;
    logic [7:0]  tag;
    logic        exr;
    logic        fl;
    logic        e_ready;
    logic        e_stall;
    logic        e_valid;
    logic [4:0]  e_wb;
    logic [7:0]  e_tag;
    logic [15:0] e_cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_operand_a;
  logic [31:0] id_operand_b;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_wb_addr;
  logic        id_has_rs1;
  logic        id_has_rs2;
  logic        id_wb_flag;
  logic        id_load_flag;
  logic        id_store_flag;
  logic [15:0] id_ctrl;
  logic        ex_ready;
  logic        flush;
  logic        id2ex_valid;
  logic [31:0] id2ex_pc;
  logic [31:0] id2ex_operand_a;
  logic [31:0] id2ex_operand_b;
  logic [4:0]  id2ex_rs1_addr;
  logic [4:0]  id2ex_rs2_addr;
  logic [4:0]  id2ex_wb_addr;
  logic        id2ex_has_rs1;
  logic        id2ex_has_rs2;
  logic        id2ex_wb_flag;
  logic        id2ex_load_flag;
  logic        id2ex_store_flag;
  logic [15:0] id2ex_ctrl;
  logic        load_use_stall;
  logic [15:0] load_use_cnt;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t instr_by_tag[256];

  ysyx_23060072_id2ex #(.CTRL_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_pc            (id_pc),
    .id_operand_a     (id_operand_a),
    .id_operand_b     (id_operand_b),
    .id_rs1_addr      (id_rs1_addr),
    .id_rs2_addr      (id_rs2_addr),
    .id_wb_addr       (id_wb_addr),
    .id_has_rs1       (id_has_rs1),
    .id_has_rs2       (id_has_rs2),
    .id_wb_flag       (id_wb_flag),
    .id_load_flag     (id_load_flag),
    .id_store_flag    (id_store_flag),
    .id_ctrl          (id_ctrl),
    .ex_ready         (ex_ready),
    .flush            (flush),
    .id2ex_valid      (id2ex_valid),
    .id2ex_pc         (id2ex_pc),
    .id2ex_operand_a  (id2ex_operand_a),
    .id2ex_operand_b  (id2ex_operand_b),
    .id2ex_rs1_addr   (id2ex_rs1_addr),
    .id2ex_rs2_addr   (id2ex_rs2_addr),
    .id2ex_wb_addr    (id2ex_wb_addr),
    .id2ex_has_rs1    (id2ex_has_rs1),
    .id2ex_has_rs2    (id2ex_has_rs2),
    .id2ex_wb_flag    (id2ex_wb_flag),
    .id2ex_load_flag  (id2ex_load_flag),
    .id2ex_store_flag (id2ex_store_flag),
    .id2ex_ctrl       (id2ex_ctrl),
    .load_use_stall   (load_use_stall),
    .load_use_cnt     (load_use_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Payload derived from the tag; tag 0 maps to the all-zero reset payload.
  function automatic logic [31:0] pc_of(input logic [7:0] t);
    return {22'd0, t, 2'b00};
  endfunction

  function automatic logic [31:0] opa_of(input logic [7:0] t);
    return {t, t, t, t};
  endfunction

  function automatic logic [31:0] opb_of(input logic [7:0] t);
    return {t, 16'd0, t};
  endfunction

  function automatic logic [15:0] ctrl_of(input logic [7:0] t);
    return {t, 8'(t * 8'd3)};
  endfunction

  function automatic vec_t mk(input int vld, input int r1, input int h1,
                              input int r2, input int h2, input int wb,
                              input int wbf, input int ld, input int st,
                              input int tag, input int exr, input int fl,
                              input int er, input int es, input int ev,
                              input int ewb, input int etag, input int ecnt);
    vec_t v;
    v         = '0;
    v.vld     = 1'(vld);
    v.rs1     = 5'(r1);
    v.hr1     = 1'(h1);
    v.rs2     = 5'(r2);
    v.hr2     = 1'(h2);
    v.wb      = 5'(wb);
    v.wbf     = 1'(wbf);
    v.ld      = 1'(ld);
    v.st      = 1'(st);
    v.tag     = 8'(tag);
    v.exr     = 1'(exr);
    v.fl      = 1'(fl);
    v.e_ready = 1'(er);
    v.e_stall = 1'(es);
    v.e_valid = 1'(ev);
    v.e_wb    = 5'(ewb);
    v.e_tag   = 8'(etag);
    v.e_cnt   = 16'(ecnt);
    return v;
  endfunction

  task automatic addRow(input vec_t v);
    v.id = 16'(tbl.size());
    tbl.push_back(v);
  endtask

  task automatic chk(input string what, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL row%0d %s: got %h expected %h", row, what, act, exp);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    instr_by_tag[v.tag] = v;
    id_valid      = v.vld;
    id_pc         = pc_of(v.tag);
    id_operand_a  = opa_of(v.tag);
    id_operand_b  = opb_of(v.tag);
    id_rs1_addr   = v.rs1;
    id_rs2_addr   = v.rs2;
    id_wb_addr    = v.wb;
    id_has_rs1    = v.hr1;
    id_has_rs2    = v.hr2;
    id_wb_flag    = v.wbf;
    id_load_flag  = v.ld;
    id_store_flag = v.st;
    id_ctrl       = ctrl_of(v.tag);
    ex_ready      = v.exr;
    flush         = v.fl;
  endtask

  // Drive one row (caller is on a falling edge), check the combinational
  // handshake outputs, and queue the post-edge expectation.
  task automatic applyStimulus(input vec_t v);
    driveInputs(v);
    #1;
    chk("id_ready", int'(v.id), 32'(id_ready), 32'(v.e_ready));
    chk("load_use_stall", int'(v.id), 32'(load_use_stall), 32'(v.e_stall));
    exp_q.push_back(v);
  endtask

  // After the next rising edge, pop one expectation and compare the whole
  // stage contents and the bubble counter.
  task automatic checkOutput();
    vec_t e;
    vec_t src;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", -1, 32'd1, 32'd0);
    end else begin
      e   = exp_q.pop_front();
      src = instr_by_tag[e.e_tag];
      chk("id2ex_valid", int'(e.id), 32'(id2ex_valid), 32'(e.e_valid));
      chk("id2ex_wb_addr", int'(e.id), 32'(id2ex_wb_addr), 32'(e.e_wb));
      chk("id2ex_pc", int'(e.id), id2ex_pc, pc_of(e.e_tag));
      chk("id2ex_operand_a", int'(e.id), id2ex_operand_a, opa_of(e.e_tag));
      chk("id2ex_operand_b", int'(e.id), id2ex_operand_b, opb_of(e.e_tag));
      chk("id2ex_ctrl", int'(e.id), 32'(id2ex_ctrl), 32'(ctrl_of(e.e_tag)));
      chk("id2ex_rs1_addr", int'(e.id), 32'(id2ex_rs1_addr), 32'(src.rs1));
      chk("id2ex_rs2_addr", int'(e.id), 32'(id2ex_rs2_addr), 32'(src.rs2));
      chk("id2ex_flags", int'(e.id),
          32'({id2ex_has_rs1, id2ex_has_rs2, id2ex_wb_flag, id2ex_load_flag, id2ex_store_flag}),
          32'({src.hr1, src.hr2, src.wbf, src.ld, src.st}));
      chk("load_use_cnt", int'(e.id), 32'(load_use_cnt), 32'(e.e_cnt));
    end
  endtask

  initial begin
    vec_t v;
    logic [15:0] cnt_model;

    instr_by_tag[0] = '0;

    // Rows: vld, rs1,h1, rs2,h2, wb,wbf, ld,st, tag, exr,fl,
    //       exp: ready, stall, valid_next, wb_next, tag_next, cnt_next
    addRow(mk(1, 1,1, 2,1, 3,1, 0,0,  1, 1,0, 1,0,1, 3, 1, 0));          // add x3,x1,x2
    addRow(mk(1, 2,1, 0,0, 5,1, 1,0,  2, 1,0, 1,0,1, 5, 2, 0));          // lw x5,0(x2)
    addRow(mk(1, 5,1, 1,1, 6,1, 0,0,  3, 1,0, 0,1,0, 5, 2, 1));          // add x6,x5,x1 bubble
    addRow(mk(1, 5,1, 1,1, 6,1, 0,0,  3, 1,0, 1,0,1, 6, 3, 1));          // add accepted
    addRow(mk(1, 2,1, 0,0, 5,1, 1,0,  4, 1,0, 1,0,1, 5, 4, 1));          // lw x5,0(x2)
    addRow(mk(1, 2,1, 5,1, 0,0, 0,1,  5, 1,0, FWD,NF,FWD,
              (FWD != 0) ? 0 : 5, (FWD != 0) ? 5 : 4, 1 + NF));          // sw x5,0(x2)
    addRow(mk(1, 2,1, 5,1, 0,0, 0,1,  5, 1,0, 1,0,1, 0, 5, 1 + NF));     // sw again / accepted
    addRow(mk(1, 2,1, 0,0, 5,1, 1,0,  6, 1,0, 1,0,1, 5, 6, 1 + NF));     // lw x5,0(x2)
    addRow(mk(1, 5,1, 7,1, 0,0, 0,1,  7, 1,0, 0,1,0, 5, 6, 2 + NF));     // sw x7,0(x5) bubble
    addRow(mk(1, 5,1, 7,1, 0,0, 0,1,  7, 1,0, 1,0,1, 0, 7, 2 + NF));     // sw accepted
    addRow(mk(1, 2,1, 0,0, 0,1, 1,0,  8, 1,0, 1,0,1, 0, 8, 2 + NF));     // lw x0,0(x2)
    addRow(mk(1, 0,1, 0,1, 1,1, 0,0,  9, 1,0, 1,0,1, 1, 9, 2 + NF));     // add x1,x0,x0
    addRow(mk(1, 3,1, 4,1,10,1, 0,0, 10, 0,0, 0,0,1, 1, 9, 2 + NF));     // EX blocked 1
    addRow(mk(1, 3,1, 4,1,10,1, 0,0, 10, 0,0, 0,0,1, 1, 9, 2 + NF));     // EX blocked 2
    addRow(mk(1, 3,1, 4,1,10,1, 0,0, 10, 0,0, 0,0,1, 1, 9, 2 + NF));     // EX blocked 3
    addRow(mk(1, 3,1, 4,1,10,1, 0,0, 10, 1,0, 1,0,1,10,10, 2 + NF));     // EX resumes
    addRow(mk(0, 0,0, 0,0, 0,0, 0,0, 11, 1,0, 1,0,0,10,10, 2 + NF));     // drain, payload kept
    addRow(mk(1, 2,1, 0,0, 5,1, 1,0, 12, 1,0, 1,0,1, 5,12, 2 + NF));     // lw x5
    addRow(mk(1, 5,1, 1,1, 6,1, 0,0, 13, 1,1, 0,0,0, 5,12, 2 + NF));     // flush over hazard
    addRow(mk(1, 5,1, 1,1, 6,1, 0,0, 13, 1,0, 1,0,1, 6,13, 2 + NF));     // accepted after flush
    addRow(mk(1, 1,1, 2,1, 7,1, 0,0, 14, 0,1, 0,0,0, 6,13, 2 + NF));     // flush while EX blocked
    addRow(mk(1, 2,1, 0,0, 5,1, 1,0, 15, 1,0, 1,0,1, 5,15, 2 + NF));     // lw x5
    addRow(mk(1, 5,1, 1,1, 6,1, 0,0, 16, 0,0, 0,1,1, 5,15, 2 + NF));     // stall, EX blocked
    addRow(mk(1, 5,1, 1,1, 6,1, 0,0, 16, 1,0, 0,1,0, 5,15, 3 + NF));     // bubble enters
    addRow(mk(1, 5,1, 1,1, 6,1, 0,0, 16, 1,0, 1,0,1, 6,16, 3 + NF));     // accepted
    addRow(mk(1, 2,1, 0,0, 5,1, 1,0, 17, 1,0, 1,0,1, 5,17, 3 + NF));     // lw x5
    addRow(mk(1, 1,1, 5,0, 6,1, 0,0, 18, 1,0, 1,0,1, 6,18, 3 + NF));     // rs2=x5 unused

    // Reset with a decode instruction presented: nothing captured, handshake open.
    rst_n = 1'b0;
    driveInputs(mk(1, 5,1, 1,1, 6,1, 0,0, 20, 1,0, 0,0,0, 0,0, 0));
    #2;
    chk("reset_valid", -1, 32'(id2ex_valid), 32'd0);
    chk("reset_pc", -1, id2ex_pc, 32'd0);
    chk("reset_wb_addr", -1, 32'(id2ex_wb_addr), 32'd0);
    chk("reset_cnt", -1, 32'(load_use_cnt), 32'd0);
    chk("reset_id_ready", -1, 32'(id_ready), 32'd1);
    chk("reset_stall", -1, 32'(load_use_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_valid_after_edge", -1, 32'(id2ex_valid), 32'd0);
    @(negedge clk);
    id_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      checkOutput();
    end

    // Reset asserted mid-cycle with a valid instruction in the stage.
    $display("[TB] reset in mid-operation");
    #2;
    rst_n = 1'b0;
    v = mk(1, 5,1, 1,1, 6,1, 0,0, 21, 1,0, 1,0,1, 6,21, 0);
    v.id = 16'd100;
    driveInputs(v);
    #1;
    chk("midreset_valid", 100, 32'(id2ex_valid), 32'd0);
    chk("midreset_pc", 100, id2ex_pc, 32'd0);
    chk("midreset_wb_addr", 100, 32'(id2ex_wb_addr), 32'd0);
    chk("midreset_cnt", 100, 32'(load_use_cnt), 32'd0);
    chk("midreset_id_ready", 100, 32'(id_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("midreset_hold", 100, 32'(id2ex_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(v);
    checkOutput();

    // Repeated load-use bubbles, with the counter preloaded near its limit.
    $display("[TB] counter saturation");
    cnt_model = 16'd0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        cnt_model = 16'hFFFD;
      end
      @(negedge clk);
      v = mk(1, 2,1, 0,0, 5,1, 1,0, 40 + 2*k, 1,0, 1,0,1, 5, 40 + 2*k, int'(cnt_model));
      v.id = 16'(200 + 2*k);
      applyStimulus(v);
      checkOutput();
      cnt_model = (cnt_model == 16'hFFFF) ? 16'hFFFF : cnt_model + 16'd1;
      @(negedge clk);
      v = mk(1, 5,1, 1,1, 6,1, 0,0, 41 + 2*k, 1,0, 0,1,0, 5, 40 + 2*k, int'(cnt_model));
      v.id = 16'(201 + 2*k);
      applyStimulus(v);
      checkOutput();
    end
    chk("cnt_saturated", 300, 32'(load_use_cnt), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
